sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter READ_WAIT, default 2, SRAM read strobe length in clocks (legal range 1..15).
REQ-002 SHALL have parameter WRITE_WAIT, default 2, SRAM write strobe length in clocks (legal range 1..15).
REQ-003 SHALL have port wb_clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe and write-enable.
REQ-006 SHALL have port wb_addr_i  in  20  byte address; bits [1:0] ignored.
REQ-007 SHALL have port wb_sel_i  in  4  byte selects, bit n = byte lane n.
REQ-008 SHALL have port wb_dat_i  in  32  write data.
REQ-009 SHALL have port wb_dat_o  out  32  read data, registered.
REQ-010 SHALL have port wb_ack_o  out  1  transfer acknowledge, registered.
REQ-011 SHALL have port sram_dat_i  in  32  SRAM read data.
REQ-012 SHALL have port sram_dat_o  out  32  SRAM write data, registered.
REQ-013 SHALL have port sram_drive_o  out  1  high when external tristate drives sram_dat_o onto the SRAM bus.
REQ-014 SHALL have ports sram_cs_o, sram_oe_o, sram_we_o  out  1 each  SRAM chip select, output enable, write enable, all active-low.
REQ-015 SHALL have port sram_addr_o  out  18  word address = latched wb_addr_i[19:2].
REQ-016 SHALL have port sram_bsel_o  out  4  active-low byte enables = inverse of latched wb_sel_i.

Function
REQ-017 SHALL implement states IDLE, SETUP, ACCESS, HOLD, ACK with a 4-bit wait counter.
REQ-018 IDLE: cs/oe/we high, ack low, drive low; on wb_cyc_i&wb_stb_i SHALL latch addr, sel, we, wb_dat_i and enter SETUP.
REQ-019 SETUP (1 clock): cs low; oe low for reads; drive high for writes; we high; counter loaded with READ_WAIT or WRITE_WAIT.
REQ-020 ACCESS: read holds oe low, write holds we low; counter decrements each clock; exit on the clock counter equals 1.
REQ-021 Read SHALL capture sram_dat_i into wb_dat_o on the last ACCESS clock, then enter ACK.
REQ-022 Write SHALL leave ACCESS to HOLD (1 clock: we high, cs low, drive high, data and address unchanged), then ACK.
REQ-023 ACK: wb_ack_o high for exactly one clock, cs high, then IDLE; no new request accepted in ACK.
REQ-024 Read ack SHALL rise READ_WAIT+2 clocks after the edge that samples the request in IDLE; write ack WRITE_WAIT+3 clocks.
REQ-025 Address, bsel, sram_dat_o SHALL remain stable from SETUP through HOLD/ACK.
REQ-026 wb_dat_o SHALL hold last read value until next read capture; writes leave it unchanged.
REQ-027 wb_cyc_i low in SETUP/ACCESS/HOLD SHALL abort: next state IDLE, all strobes deasserted, no ack.
REQ-028 wb_sel_i = 0 SHALL run a full cycle with all sram_bsel_o high and still ack.
REQ-029 Back-to-back: stb held after ack SHALL start the next transfer from IDLE on the following clock (one idle clock minimum).

Reset
REQ-030 Reset SHALL force IDLE asynchronously: ack 0, cs/oe/we 1, bsel 4'hF, drive 0, addr 0, sram_dat_o 0, wb_dat_o 0, counter 0.
REQ-031 Reset mid-write SHALL deassert sram_we_o immediately, without waiting for a clock edge.

Structure
REQ-032 State encodings and default wait constants SHALL live in the shared defines file next to the MODE_* constants.
REQ-033 No sub-module SHALL be used; counter and FSM reside in sram_ctrl.

Verification
REQ-034 Read addr 0x00104, READ_WAIT=2, sram_dat_i=0xDEADBEEF -> sram_addr_o=0x00041, oe low 3 clocks, ack 4 clocks after request, wb_dat_o=0xDEADBEEF.
REQ-035 Write 0x12345678 sel 4'b0101, WRITE_WAIT=2 -> bsel 4'b1010, we low 2 clocks, ack 5 clocks after request.
REQ-036 Drop wb_cyc_i in second ACCESS clock of a write -> we high next clock, no ack, IDLE.
REQ-037 Assert reset mid-read -> all strobes inactive before next edge, wb_dat_o=0.
REQ-038 Two back-to-back reads with stb held -> two single-clock acks, separated by one idle clock.
REQ-039 Write with sel=0 -> all bsel high throughout, ack still returned.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, transfer modes and default strobe lengths
package sram_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ACK} state_t;
    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_WRITE = 1'b1;
    localparam int DEF_READ_WAIT = 2;
    localparam int DEF_WRITE_WAIT = 2;
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: Wishbone slave port plus SRAM pin bundle for sram_ctrl
interface sram_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [19:0] wb_addr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [31:0] sram_dat_i;
    logic [31:0] sram_dat_o;
    logic        sram_drive_o;
    logic        sram_cs_o;
    logic        sram_oe_o;
    logic        sram_we_o;
    logic [17:0] sram_addr_o;
    logic [3:0]  sram_bsel_o;
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i, sram_dat_i,
        output wb_dat_o, wb_ack_o, sram_dat_o, sram_drive_o, sram_cs_o, sram_oe_o,
               sram_we_o, sram_addr_o, sram_bsel_o
    );
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i, sram_dat_i,
        input  wb_dat_o, wb_ack_o, sram_dat_o, sram_drive_o, sram_cs_o, sram_oe_o,
               sram_we_o, sram_addr_o, sram_bsel_o
    );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: Wishbone slave driving an asynchronous 32-bit SRAM with
// programmable read/write strobe lengths; all SRAM pins are registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
    input logic        wb_clk_i,
    input logic        wb_rst_i,
    sram_ctrl_if.slave bus
);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [17:0] addr_q, addr_d;
    logic [3:0]  bsel_q, bsel_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        ack_q, ack_d;
    logic        cs_q, cs_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        drive_q, drive_d;
    logic        busy_d;
    logic        unused_addr;
    assign unused_addr = ^bus.wb_addr_i[1:0];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        bsel_d  = bsel_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.wb_cyc_i && bus.wb_stb_i) begin
                state_d = SETUP;
                mode_d  = bus.wb_we_i;
                addr_d  = bus.wb_addr_i[19:2];
                bsel_d  = ~bus.wb_sel_i;
                wdat_d  = bus.wb_dat_i;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = mode_q == MODE_WRITE ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = mode_q == MODE_WRITE ? HOLD : ACK;
                    rdat_d  = mode_q == MODE_WRITE ? rdat_q : bus.sram_dat_i;
                end
            end
            HOLD: state_d = ACK;
            ACK: begin
                state_d = IDLE;
                ack_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Master giving up the cycle abandons the access; nothing is captured or acked.
        if (!bus.wb_cyc_i && state_q inside {SETUP, ACCESS, HOLD}) begin
            state_d = IDLE;
            cnt_d   = '0;
            rdat_d  = rdat_q;
        end
        busy_d  = state_d inside {SETUP, ACCESS, HOLD};
        cs_d    = !busy_d;
        oe_d    = !(mode_d == MODE_READ && state_d inside {SETUP, ACCESS});
        we_d    = !(mode_d == MODE_WRITE && state_d == ACCESS);
        drive_d = mode_d == MODE_WRITE && busy_d;
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_READ;
            addr_q  <= '0;
            bsel_q  <= 4'hF;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            cs_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            bsel_q  <= bsel_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            drive_q <= drive_d;
        end
    end
    assign bus.wb_dat_o     = rdat_q;
    assign bus.wb_ack_o     = ack_q;
    assign bus.sram_dat_o   = wdat_q;
    assign bus.sram_drive_o = drive_q;
    assign bus.sram_cs_o    = cs_q;
    assign bus.sram_oe_o    = oe_q;
    assign bus.sram_we_o    = we_q;
    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_bsel_o  = bsel_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed transfers against an elapsed-time model of the
// controller's pin timing, plus hand-computed literal expectations.
module tb_sram_ctrl;
    localparam int RW = 2;
    localparam int WW = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    sram_ctrl_if bus();
    sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: a transfer accepted at edge t0 keeps cs low for len clocks
    // (read: setup + RW, write: setup + WW + hold); ack follows one clock later.
    int n = 0;
    int t0 = 0;
    int k;
    int len;
    logic busy = 1'b0;
    logic m_we = 1'b0;
    logic [17:0] m_addr = '0;
    logic [3:0]  m_bsel = 4'hF;
    logic [31:0] m_wd = '0;
    logic [31:0] m_rd = '0;
    always @(posedge clk) begin
        n++;
        if (rst) begin
            busy = 1'b0;
            m_addr = '0;
            m_bsel = 4'hF;
            m_wd = '0;
            m_rd = '0;
        end else begin
            if (busy) begin
                k = n - t0;
                len = m_we ? WW + 2 : RW + 1;
                if (k - 1 <= len - 1 && !bus.wb_cyc_i) busy = 1'b0;
                else begin
                    if (!m_we && k == RW + 1) m_rd = bus.sram_dat_i;
                    if (k >= len + 2) busy = 1'b0;
                end
            end
            if (!busy && bus.wb_cyc_i && bus.wb_stb_i) begin
                busy = 1'b1;
                t0 = n;
                m_we = bus.wb_we_i;
                m_addr = bus.wb_addr_i[19:2];
                m_bsel = ~bus.wb_sel_i;
                m_wd = bus.wb_dat_i;
            end
        end
        #1;
        k = n - t0;
        len = m_we ? WW + 2 : RW + 1;
        chk("cs", 32'(bus.sram_cs_o), 32'(!(busy && k <= len - 1)));
        chk("oe", 32'(bus.sram_oe_o), 32'(!(busy && !m_we && k <= RW)));
        chk("we", 32'(bus.sram_we_o), 32'(!(busy && m_we && k >= 1 && k <= WW)));
        chk("drive", 32'(bus.sram_drive_o), 32'(busy && m_we && k <= WW + 1));
        chk("ack", 32'(bus.wb_ack_o), 32'(busy && k == len + 1));
        chk("addr", 32'(bus.sram_addr_o), 32'(m_addr));
        chk("bsel", 32'(bus.sram_bsel_o), 32'(m_bsel));
        chk("sram_dat_o", bus.sram_dat_o, m_wd);
        chk("wb_dat_o", bus.wb_dat_o, m_rd);
    end
    int oe_lo = 0;
    int we_lo = 0;
    always @(negedge clk) begin
        if (!bus.sram_oe_o) oe_lo++;
        if (!bus.sram_we_o) we_lo++;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
    task automatic xfer(input logic w, input logic [19:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int lat);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i = w;
        bus.wb_addr_i = a;
        bus.wb_sel_i = s;
        bus.wb_dat_i = d;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.wb_ack_o && lat < 20);
        @(negedge clk);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask
    initial begin
        int lat, o0, w0, a1, gap, acks;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i = 1'b0;
        bus.wb_addr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;
        bus.sram_dat_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        chk("rst_cs", 32'(bus.sram_cs_o), 32'h1);
        chk("rst_oe", 32'(bus.sram_oe_o), 32'h1);
        chk("rst_we", 32'(bus.sram_we_o), 32'h1);
        chk("rst_bsel", 32'(bus.sram_bsel_o), 32'hF);
        chk("rst_addr", 32'(bus.sram_addr_o), 32'h0);
        chk("rst_dat_o", bus.wb_dat_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.sram_dat_i = 32'hDEADBEEF;
        o0 = oe_lo;
        xfer(1'b0, 20'h00104, 4'hF, 32'h0, lat);
        chk("rd_latency", lat, 4);
        chk("rd_addr", 32'(bus.sram_addr_o), 32'h00041);
        chk("rd_data", bus.wb_dat_o, 32'hDEADBEEF);
        chk("rd_oe_clocks", oe_lo - o0, 3);
        w0 = we_lo;
        xfer(1'b1, 20'h00200, 4'b0101, 32'h12345678, lat);
        chk("wr_latency", lat, 5);
        chk("wr_bsel", 32'(bus.sram_bsel_o), 32'hA);
        chk("wr_sram_dat", bus.sram_dat_o, 32'h12345678);
        chk("wr_we_clocks", we_lo - w0, 2);
        chk("wr_keeps_dat_o", bus.wb_dat_o, 32'hDEADBEEF);
        xfer(1'b1, 20'h00300, 4'b0000, 32'hA5A5A5A5, lat);
        chk("sel0_latency", lat, 5);
        chk("sel0_bsel", 32'(bus.sram_bsel_o), 32'hF);
        @(negedge clk);
        bus.sram_dat_i = 32'hCAFEF00D;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i = 1'b0;
        bus.wb_addr_i = 20'h00208;
        bus.wb_sel_i = 4'hF;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.wb_ack_o && lat < 20);
        a1 = lat;
        chk("b2b_first_data", bus.wb_dat_o, 32'hCAFEF00D);
        @(negedge clk);
        bus.wb_addr_i = 20'h0030C;
        bus.sram_dat_i = 32'h0BADF00D;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.wb_ack_o && lat < 40);
        gap = lat - a1;
        @(negedge clk);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        chk("b2b_first_ack", a1, 5);
        chk("b2b_ack_gap", gap, 5);
        chk("b2b_second_data", bus.wb_dat_o, 32'h0BADF00D);
        chk("b2b_second_addr", 32'(bus.sram_addr_o), 32'h000C3);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i = 1'b1;
        bus.wb_addr_i = 20'h00400;
        bus.wb_dat_i = 32'h55AA55AA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_we_low", 32'(bus.sram_we_o), 32'h0);
        bus.wb_cyc_i = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_we_high", 32'(bus.sram_we_o), 32'h1);
        chk("abort_cs_high", 32'(bus.sram_cs_o), 32'h1);
        chk("abort_drive", 32'(bus.sram_drive_o), 32'h0);
        acks = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.wb_ack_o) acks++;
        end
        chk("abort_no_ack", acks, 0);
        @(negedge clk);
        bus.wb_stb_i = 1'b0;
        bus.sram_dat_i = 32'h11112222;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i = 1'b0;
        bus.wb_addr_i = 20'h00500;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rrst_oe_low", 32'(bus.sram_oe_o), 32'h0);
        #2;
        rst = 1'b1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        #1;
        chk("rrst_cs", 32'(bus.sram_cs_o), 32'h1);
        chk("rrst_oe", 32'(bus.sram_oe_o), 32'h1);
        chk("rrst_we", 32'(bus.sram_we_o), 32'h1);
        chk("rrst_ack", 32'(bus.wb_ack_o), 32'h0);
        chk("rrst_dat_o", bus.wb_dat_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i = 1'b1;
        bus.wb_addr_i = 20'h00600;
        bus.wb_dat_i = 32'h600DCAFE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("wrst_we_low", 32'(bus.sram_we_o), 32'h0);
        #2;
        rst = 1'b1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        #1;
        chk("wrst_we", 32'(bus.sram_we_o), 32'h1);
        chk("wrst_drive", 32'(bus.sram_drive_o), 32'h0);
        chk("wrst_bsel", 32'(bus.sram_bsel_o), 32'hF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.sram_dat_i = 32'h87654321;
        xfer(1'b0, 20'hFFFFC, 4'hF, 32'h0, lat);
        chk("top_latency", lat, 4);
        chk("top_addr", 32'(bus.sram_addr_o), 32'h3FFFF);
        chk("top_data", bus.wb_dat_o, 32'h87654321);
        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
